mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port 8-bit `memoria` between the mRisc memory port (port 0) and a second requester (port 1: loader/debug/DMA).
- Sits between the requesters and `memoria` and drives the memory's address, write-data and write-enable.
- Sequences each access through a small state machine with a req/ack handshake.
- Round-robin fairness; no requester starves.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_pick2.sv | 22 ++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types and constants.
// State encoding, port indices, grant-counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick.
// On a tie the port that was not granted last wins.
module rr_pick2 (
  input  logic Req0,
  input  logic Req1,
  input  logic Last,
  output logic Valid,
  output logic Grant
);

  // Combinational select; Grant is meaningful only with Valid.
  always_comb begin
    Valid = Req0 | Req1;
    Grant = 1'b0;
    unique case (1'b1)
      (Req0 & Req1):  Grant = ~Last;
      (Req1 & ~Req0): Grant = 1'b1;
      default:        Grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter in front of a single-port memory.
// Optional grant counters: define MEM_ARB_STATS_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Req0,
  input  logic             We0,
  input  logic [AW-1:0]    Addr0,
  input  logic [DW-1:0]    WData0,
  output logic [DW-1:0]    RData0,
  output logic             Ack0,
  input  logic             Req1,
  input  logic             We1,
  input  logic [AW-1:0]    Addr1,
  input  logic [DW-1:0]    WData1,
  output logic [DW-1:0]    RData1,
  output logic             Ack1,
  output logic [AW-1:0]    MemAddr,
  output logic [DW-1:0]    MemWData,
  output logic             MemWe,
  input  logic [DW-1:0]    MemRData,
  output logic [CNT_W-1:0] Cnt0,
  output logic [CNT_W-1:0] Cnt1
);

  localparam int LW = 3;

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_chk
    $error("mem_arbiter: MEM_LAT must be 1..4");
  end

  state_e          state_q;
  logic            last_q;
  logic            grant_q;
  logic            we_q;
  logic [LW-1:0]   lat_q;
  logic [AW-1:0]   maddr_q;
  logic [DW-1:0]   mwdata_q;
  logic            mwe_q;
  logic            ack0_q;
  logic            ack1_q;
  logic [DW-1:0]   rdata0_q;
  logic [DW-1:0]   rdata1_q;

  logic            pick_v;
  logic            pick_g;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  rr_pick2 u_pick (
    .Req0  (Req0),
    .Req1  (Req1),
    .Last  (last_q),
    .Valid (pick_v),
    .Grant (pick_g)
  );

  // Request fields of whichever port the picker chose.
  always_comb begin
    sel_we    = We0;
    sel_addr  = Addr0;
    sel_wdata = WData0;
    if (pick_g == PORT_AUX) begin
      sel_we    = We1;
      sel_addr  = Addr1;
      sel_wdata = WData1;
    end
  end

  // Access sequencer; all memory and port outputs are registered here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      last_q   <= PORT_AUX;
      grant_q  <= PORT_CPU;
      we_q     <= 1'b0;
      lat_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwe_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      mwe_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_v) begin
            grant_q <= pick_g;
            last_q  <= pick_g;
            we_q    <= sel_we;
            maddr_q <= sel_addr;
            if (sel_we) begin
              mwdata_q <= sel_wdata;
              mwe_q    <= 1'b1;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            ack0_q  <= (grant_q == PORT_CPU);
            ack1_q  <= (grant_q == PORT_AUX);
            state_q <= DONE;
          end else begin
            lat_q   <= LW'(MEM_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (lat_q == LW'(1)) begin
            if (grant_q == PORT_AUX) begin
              rdata1_q <= MemRData;
              ack1_q   <= 1'b1;
            end else begin
              rdata0_q <= MemRData;
              ack0_q   <= 1'b1;
            end
            state_q <= DONE;
          end
          lat_q <= lat_q - LW'(1);
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MemAddr  = maddr_q;
  assign MemWData = mwdata_q;
  assign MemWe    = mwe_q;
  assign Ack0     = ack0_q;
  assign Ack1     = ack1_q;
  assign RData0   = rdata0_q;
  assign RData1   = rdata1_q;

`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Count grants per port as they enter ISSUE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state_q == IDLE && pick_v) begin
      if (pick_g == PORT_AUX) cnt1_q <= sat_inc(cnt1_q);
      else                    cnt0_q <= sat_inc(cnt0_q);
    end
  end

  assign Cnt0 = cnt0_q;
  assign Cnt1 = cnt1_q;
`else
  assign Cnt0 = '0;
  assign Cnt1 = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Instance a: MEM_LAT=1, instance b: MEM_LAT=3.
module tb_mem_arbiter;

`ifdef MEM_ARB_STATS_EN
  localparam int EXP_CNT = 5;
`else
  localparam int EXP_CNT = 0;
`endif

  logic CLK;
  logic RST_N;

  logic        a_req0, a_we0, a_req1, a_we1;
  logic [7:0]  a_addr0, a_wd0, a_addr1, a_wd1;
  logic [7:0]  a_rd0, a_rd1, a_maddr, a_mwd, a_mrd;
  logic        a_ack0, a_ack1, a_mwe;
  logic [15:0] a_cnt0, a_cnt1;

  logic        b_req0, b_we0, b_req1, b_we1;
  logic [7:0]  b_addr0, b_wd0, b_addr1, b_wd1;
  logic [7:0]  b_rd0, b_rd1, b_maddr, b_mwd, b_mrd;
  logic        b_ack0, b_ack1, b_mwe;
  logic [15:0] b_cnt0, b_cnt1;

  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  logic [7:0]  b_p1, b_p2;

  int nchk;
  int nerr;

  mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(1)) u_a (
    .CLK(CLK), .RST_N(RST_N),
    .Req0(a_req0), .We0(a_we0), .Addr0(a_addr0),
    .WData0(a_wd0), .RData0(a_rd0), .Ack0(a_ack0),
    .Req1(a_req1), .We1(a_we1), .Addr1(a_addr1),
    .WData1(a_wd1), .RData1(a_rd1), .Ack1(a_ack1),
    .MemAddr(a_maddr), .MemWData(a_mwd), .MemWe(a_mwe),
    .MemRData(a_mrd), .Cnt0(a_cnt0), .Cnt1(a_cnt1)
  );

  mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(3)) u_b (
    .CLK(CLK), .RST_N(RST_N),
    .Req0(b_req0), .We0(b_we0), .Addr0(b_addr0),
    .WData0(b_wd0), .RData0(b_rd0), .Ack0(b_ack0),
    .Req1(b_req1), .We1(b_we1), .Addr1(b_addr1),
    .WData1(b_wd1), .RData1(b_rd1), .Ack1(b_ack1),
    .MemAddr(b_maddr), .MemWData(b_mwd), .MemWe(b_mwe),
    .MemRData(b_mrd), .Cnt0(b_cnt0), .Cnt1(b_cnt1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model a: one-cycle registered read.
  always @(posedge CLK) begin
    if (!RST_N) mem_a[8'h20] <= 8'h3C;
    else if (a_mwe) mem_a[a_maddr] <= a_mwd;
    a_mrd <= mem_a[a_maddr];
  end

  // Memory model b: three-cycle read pipeline.
  always @(posedge CLK) begin
    if (b_mwe) mem_b[b_maddr] <= b_mwd;
    b_p1  <= mem_b[b_maddr];
    b_p2  <= b_p1;
    b_mrd <= b_p2;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int k;
    int c;
    int t0;
    int t1;
    logic seen;
    nchk = 0;
    nerr = 0;
    RST_N = 1'b0;
    {a_req0, a_we0, a_req1, a_we1} = '0;
    {a_addr0, a_wd0, a_addr1, a_wd1} = '0;
    {b_req0, b_we0, b_req1, b_we1} = '0;
    {b_addr0, b_wd0, b_addr1, b_wd1} = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_maddr", a_maddr, 8'h00);
    check("rst_mwd", a_mwd, 8'h00);
    check("rst_mwe", a_mwe, 1'b0);
    check("rst_ack", {a_ack0, a_ack1}, 2'b00);
    check("rst_rdata", {a_rd0, a_rd1}, 16'h0000);
    check("rst_cnt", {a_cnt0, a_cnt1}, 32'h0);
    RST_N = 1'b1;
    tick();

    // contention after reset: port 0 first
    a_req0 = 1'b1; a_we0 = 1'b1;
    a_addr0 = 8'h01; a_wd0 = 8'h11;
    a_req1 = 1'b1; a_we1 = 1'b1;
    a_addr1 = 8'h02; a_wd1 = 8'h22;
    tick();
    check("cont_c1_mwe", a_mwe, 1'b1);
    check("cont_c1_addr", a_maddr, 8'h01);
    check("cont_c1_wd", a_mwd, 8'h11);
    tick();
    check("cont_c2_ack", {a_ack0, a_ack1}, 2'b10);
    check("cont_c2_mwe", a_mwe, 1'b0);
    tick();
    a_req0 = 1'b0;
    check("cont_c3_ack", {a_ack0, a_ack1}, 2'b00);
    tick();
    check("cont_c4_addr", a_maddr, 8'h02);
    check("cont_c4_mwe", a_mwe, 1'b1);
    check("cont_c4_wd", a_mwd, 8'h22);
    tick();
    check("cont_c5_ack", {a_ack0, a_ack1}, 2'b01);
    tick();
    a_req1 = 1'b0;
    check("cont_mem1", mem_a[8'h01], 8'h11);
    check("cont_mem2", mem_a[8'h02], 8'h22);

    // single write on port 0
    a_req0 = 1'b1; a_we0 = 1'b1;
    a_addr0 = 8'h10; a_wd0 = 8'hA5;
    tick();
    check("wr_c1_mwe", a_mwe, 1'b1);
    check("wr_c1_addr", a_maddr, 8'h10);
    check("wr_c1_wd", a_mwd, 8'hA5);
    check("wr_c1_ack", a_ack0, 1'b0);
    tick();
    check("wr_c2_ack", a_ack0, 1'b1);
    check("wr_c2_mwe", a_mwe, 1'b0);
    tick();
    a_req0 = 1'b0;
    check("wr_c3_ack", a_ack0, 1'b0);
    check("wr_mem", mem_a[8'h10], 8'hA5);

    // fairness from reset: 10 back-to-back writes
    RST_N = 1'b0;
    #1;
    RST_N = 1'b1;
    a_req0 = 1'b1; a_we0 = 1'b1;
    a_addr0 = 8'h50; a_wd0 = 8'h05;
    a_req1 = 1'b1; a_we1 = 1'b1;
    a_addr1 = 8'h51; a_wd1 = 8'h15;
    k = 0;
    c = 0;
    while (k < 10 && c < 60) begin
      tick();
      c++;
      if (a_ack0 | a_ack1) begin
        check("fair_order", {a_ack0, a_ack1},
              (k % 2 == 0) ? 2'b10 : 2'b01);
        k++;
      end
    end
    a_req0 = 1'b0;
    a_req1 = 1'b0;
    check("fair_total", k, 10);
    tick();
    check("fair_cnt0", a_cnt0, EXP_CNT);
    check("fair_cnt1", a_cnt1, EXP_CNT);

    // single read on port 1, MEM_LAT=1
    a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 8'h20;
    tick();
    check("rd_c1_addr", a_maddr, 8'h20);
    check("rd_c1_mwe", a_mwe, 1'b0);
    tick();
    check("rd_c2_ack", a_ack1, 1'b0);
    check("rd_c2_mwe", a_mwe, 1'b0);
    tick();
    check("rd_c3_ack", {a_ack0, a_ack1}, 2'b01);
    check("rd_c3_data", a_rd1, 8'h3C);
    tick();
    a_req1 = 1'b0;
    tick();

    // write on port 1 leaves RData1 alone
    a_req1 = 1'b1; a_we1 = 1'b1;
    a_addr1 = 8'h30; a_wd1 = 8'h55;
    tick();
    tick();
    check("hold_ack", a_ack1, 1'b1);
    check("hold_rdata", a_rd1, 8'h3C);
    tick();
    a_req1 = 1'b0;
    tick();

    // reset in the middle of a read
    a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 8'h20;
    tick();
    tick();
    RST_N = 1'b0;
    #1;
    check("mrst_maddr", a_maddr, 8'h00);
    check("mrst_rdata", a_rd1, 8'h00);
    check("mrst_ack", {a_ack0, a_ack1}, 2'b00);
    check("mrst_cnt", a_cnt1, 16'h0);
    a_req1 = 1'b0;
    tick();
    RST_N = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | a_ack0 | a_ack1 | a_mwe;
    end
    check("mrst_noack", seen, 1'b0);
    check("mrst_idle_addr", a_maddr, 8'h00);

    // read-after-write, MEM_LAT=3 (instance b)
    b_req0 = 1'b1; b_we0 = 1'b1;
    b_addr0 = 8'h40; b_wd0 = 8'h99;
    c = 0;
    while (!b_ack0 && c < 10) begin
      tick();
      c++;
    end
    check("raw_pre_ack", b_ack0, 1'b1);
    tick();
    b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 8'hFE;
    b_req1 = 1'b1; b_we1 = 1'b1;
    b_addr1 = 8'hFE; b_wd1 = 8'h77;
    t0 = 0;
    t1 = 0;
    c = 0;
    while (t0 == 0 && c < 20) begin
      tick();
      c++;
      if (b_ack1) begin
        t1 = c;
        b_req1 = 1'b0;
      end
      if (b_ack0) begin
        t0 = c;
        b_req0 = 1'b0;
        check("raw_rdata", b_rd0, 8'h77);
      end
    end
    check("raw_ack1_cyc", t1, 2);
    check("raw_ack0_cyc", t0, 8);
    check("raw_gap", t0 - t1, 6);
    check("raw_mem", mem_b[8'hFE], 8'h77);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
